// File: rtl/gray_codec_pkg.sv
// Shared definitions for the Gray/binary codec pipeline: mode encodings,
// the per-stage payload carried between register stages, and popcount.
package gray_codec_pkg;

    localparam logic MODE_G2B = 1'b0;
    localparam logic MODE_B2G = 1'b1;

    // Payload fields are sized for the widest legal configuration. Narrower
    // instances zero-fill the upper bits, which keeps the prefix-XOR carry
    // into the MSB at 0.
    localparam int unsigned MAX_W     = 32;
    localparam int unsigned MAX_TAG_W = 32;

    typedef struct packed {
        logic [MAX_W-1:0]     data;     // original input word
        logic [MAX_W-1:0]     partial;  // converted bits produced so far
        logic                 mode;
        logic [MAX_TAG_W-1:0] tag;
        logic                 valid;
    } stage_payload_t;

    function automatic logic [5:0] popcount(input logic [MAX_W-1:0] v);
        logic [5:0] n;
        n = '0;
        for (int unsigned i = 0; i < MAX_W; i++) begin
            n = n + {5'd0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/gray_codec_stage.sv
// One pipeline register stage. In Gray-to-binary mode it resolves the
// prefix-XOR chain for bits HI down to LO, seeded by the already-resolved
// bit HI+1 from the previous stage. The FIRST stage also performs the whole
// binary-to-Gray conversion; later stages pass that result through.
module gray_codec_stage
    import gray_codec_pkg::*;
#(
    parameter int unsigned HI    = 7,
    parameter int unsigned LO    = 0,
    parameter bit          FIRST = 1'b1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    input  stage_payload_t pl_i,
    output stage_payload_t pl_o
);

    stage_payload_t  pl_d;
    stage_payload_t  pl_q;
    logic [MAX_W:0]  prefix_ext;
    logic            carry;

    // Slice conversion for this stage's bit range
    always_comb begin
        pl_d       = pl_i;
        prefix_ext = {1'b0, pl_i.partial};
        carry      = 1'(prefix_ext >> (HI + 1));
        if (pl_i.mode == MODE_G2B) begin
            for (int unsigned k = 0; k <= HI - LO; k++) begin
                carry                = carry ^ pl_i.data[HI - k];
                pl_d.partial[HI - k] = carry;
            end
        end else if (FIRST) begin
            pl_d.partial = pl_i.data ^ (pl_i.data >> 1);
        end
    end

    // Stage register: cleared by reset, advances only when the pipe moves
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pl_q <= '0;
        end else if (en) begin
            pl_q <= pl_d;
        end
    end

    assign pl_o = pl_q;

endmodule

// File: rtl/gray_codec_pipe.sv
// Pipelined Gray<->binary converter with per-word direction and tag,
// valid/ready on both sides and a global stall.
// Optional unit-distance checker on Gray inputs: define GRAY_CHECK_EN.
module gray_codec_pipe
    import gray_codec_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned STAGES = 2,
    parameter int unsigned TAG_W  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_mode,
    input  logic [WIDTH-1:0] in_data,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_mode,
    output logic [TAG_W-1:0] out_tag
`ifdef GRAY_CHECK_EN
    ,
    output logic             gray_err
`endif
);

    stage_payload_t pipe_in;
    stage_payload_t pipe_out [1:STAGES];
    logic           unused_payload;

    // Pack the incoming word into a zero-filled payload
    always_comb begin
        pipe_in                   = '0;
        pipe_in.data[WIDTH-1:0]   = in_data;
        pipe_in.mode              = in_mode;
        pipe_in.tag[TAG_W-1:0]    = in_tag;
        pipe_in.valid             = in_valid;
    end

    // Bits are split MSB-first so each stage's carry comes from the stage before
    for (genvar s = 1; s <= STAGES; s++) begin : g_stage
        if (s == 1) begin : g_first
            gray_codec_stage #(
                .HI    (WIDTH - 1 - ((s - 1) * WIDTH) / STAGES),
                .LO    (WIDTH - (s * WIDTH) / STAGES),
                .FIRST (1'b1)
            ) u_stage (
                .clk  (clk),
                .rst  (rst),
                .en   (in_ready),
                .pl_i (pipe_in),
                .pl_o (pipe_out[s])
            );
        end else begin : g_next
            gray_codec_stage #(
                .HI    (WIDTH - 1 - ((s - 1) * WIDTH) / STAGES),
                .LO    (WIDTH - (s * WIDTH) / STAGES),
                .FIRST (1'b0)
            ) u_stage (
                .clk  (clk),
                .rst  (rst),
                .en   (in_ready),
                .pl_i (pipe_out[s-1]),
                .pl_o (pipe_out[s])
            );
        end
    end

    assign out_valid = pipe_out[STAGES].valid;
    assign in_ready  = !out_valid || out_ready;
    assign out_data  = out_valid ? pipe_out[STAGES].partial[WIDTH-1:0] : '0;
    assign out_mode  = pipe_out[STAGES].mode;
    assign out_tag   = pipe_out[STAGES].tag[TAG_W-1:0];

    assign unused_payload = ^{pipe_out[STAGES].data, pipe_out[STAGES].partial,
                              pipe_out[STAGES].tag};

`ifdef GRAY_CHECK_EN
    logic [WIDTH-1:0]  last_d, last_q;
    logic              seen_d, seen_q;
    logic [STAGES-1:0] err_d, err_q;
    logic              hit;

    // Compare each accepted Gray word with the previous one; the flag then
    // rides a shift register in lockstep with the word so it leaves with it
    always_comb begin
        last_d = last_q;
        seen_d = seen_q;
        err_d  = err_q;
        hit    = 1'b0;
        if (in_valid && in_ready && in_mode == MODE_G2B) begin
            hit    = seen_q && (popcount(MAX_W'(in_data ^ last_q)) > 6'd1);
            last_d = in_data;
            seen_d = 1'b1;
        end
        if (in_ready) begin
            err_d[0] = hit;
            for (int unsigned s = 1; s < STAGES; s++) begin
                err_d[s] = err_q[s-1];
            end
        end
    end

    // Checker state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= '0;
            seen_q <= 1'b0;
            err_q  <= '0;
        end else begin
            last_q <= last_d;
            seen_q <= seen_d;
            err_q  <= err_d;
        end
    end

    assign gray_err = out_valid && err_q[STAGES-1];
`endif

endmodule
